inst_fetch: RTL and testbench
=============================

# inst_fetch

Instruction fetch/issue stage directly upstream of the single-cycle CPU core. It reads the word at the CPU's current `inst_addr` from instruction memory and presents it to the core as a one-cycle `in_valid`/`inst` pulse. It then waits for the core's `out_valid`/`inst_addr` completion handshake and repeats. It enforces the core protocol: one instruction in flight, bounded latency, aligned in-range PC. It halts with an error code on any violation.

## Interface
- `IMEM_DEPTH`, 352: instruction memory depth in 32-bit words.
- `IMEM_AW`, 9: word-address width; must satisfy 2^IMEM_AW >= IMEM_DEPTH.
- `TIMEOUT`, 10: maximum cycles spent waiting in WAIT_MEM or WAIT_CPU.
- `N_INST`, 1000: number of instructions to retire before DONE.
- `clk`  in  1  sole clock; all logic is rising-edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  begin a run at PC 0; sampled only in IDLE, DONE or HALT.
- `cpu_out_valid`  in  1  core completion pulse.
- `cpu_inst_addr`  in  32  next PC from the core; byte address, valid with `cpu_out_valid`.
- `cpu_in_valid`  out  1  one-cycle instruction-issue pulse.
- `cpu_inst`  out  32  instruction word; 0 whenever `cpu_in_valid` = 0.
- `imem_req`  out  1  memory read request, one cycle.
- `imem_addr`  out  IMEM_AW  word address (PC>>2).
- `imem_rvalid`  in  1  read data valid.
- `imem_rdata`  in  32  read data.
- `busy`  out  1  high in every state except IDLE, DONE and HALT.
- `done`  out  1  high in DONE.
- `err_code`  out  3  0 none, 1 misaligned PC, 2 PC out of range, 3 memory timeout, 4 core timeout, 5 protocol violation.
- `inst_count`  out  32  instructions issued in the current run.

## Operation
- States: IDLE, CHECK, FETCH, WAIT_MEM, ISSUE, WAIT_CPU, DONE, HALT.
- IDLE/DONE/HALT + `start`:
  - pc=0, inst_count=0, err_code=0, go to CHECK.
- CHECK:
  - pc[1:0]!=0: HALT, err 1.
  - else (pc>>2) >= IMEM_DEPTH: HALT, err 2.
  - else go to FETCH.
  - Out-of-range comparison uses the full 32-bit pc, so no wrap-around aliasing.
- FETCH:
  - `imem_req`=1, `imem_addr`=pc[IMEM_AW+1:2].
  - Always go to WAIT_MEM with wait counter=0.
- WAIT_MEM:
  - `imem_rvalid`: register `imem_rdata` into `cpu_inst`, go to ISSUE.
  - else counter++; counter reaching TIMEOUT-1 without rvalid: HALT, err 3.
- ISSUE:
  - `cpu_in_valid`=1 for exactly this cycle, inst_count++.
  - Go to WAIT_CPU, counter=0.
- WAIT_CPU:
  - `cpu_out_valid`: pc=`cpu_inst_addr`; go to DONE if inst_count==N_INST, else CHECK.
  - else counter++; reaching TIMEOUT-1: HALT, err 4.
- Protocol violation: `cpu_out_valid`=1 in any state other than WAIT_CPU, including a second consecutive cycle → HALT, err 5. This has priority over all other transitions except `rst`.
- `imem_rvalid` outside WAIT_MEM is ignored.
- `start` in busy states is ignored.
- HALT and DONE hold pc, inst_count and err_code until `start` or `rst`.
- Counters are saturating; inst_count never wraps (N_INST < 2^32).

## Timing
- Reset: state IDLE; all outputs 0 (`cpu_in_valid`, `cpu_inst`, `imem_req`, `imem_addr`, `busy`, `done`, `err_code`, `inst_count`); pc=0.
  - `rst` mid-run aborts immediately; a pending memory response is discarded.
- All outputs are registered or decoded from the registered state. There is no combinational path from input to output.
- Zero-wait memory (rvalid the cycle after req): `start` sampled at edge 0 → CHECK cycle 1, FETCH cycle 2, WAIT_MEM cycle 3 (rvalid), ISSUE cycle 4.
- Steady state: `cpu_out_valid` sampled at edge c → next `cpu_in_valid` in cycle c+4.
- With a memory latency of L cycles, add L-1 cycles.
- `cpu_inst` is valid only in the ISSUE cycle and returns to 0 the next cycle.

## Test plan
- Sequential run:
  - Stimulus: memory holds words 0..N-1 with N_INST=4; core model returns inst_addr+4 two cycles after each `cpu_in_valid`.
  - Required: 4 issue pulses carrying words 0,1,2,3; each issue 4 cycles after the previous `out_valid`; `done`=1, `inst_count`=4, `err_code`=0.
- Jump target and alignment:
  - Core returns 0x20 → next `imem_addr`=8.
  - Core returns 0x22 → HALT, err 1, with no `imem_req`.
  - Core returns 0x580 (word 352) → HALT, err 2.
- Timeouts:
  - Memory never asserts rvalid → HALT with err 3 after 10 cycles in WAIT_MEM.
  - Core never asserts out_valid → HALT with err 4.
- Protocol violation: `cpu_out_valid` held for 2 cycles → HALT, err 5 in the second cycle.
- Reset during WAIT_MEM, with rvalid arriving in the following cycle → all outputs 0, IDLE, response ignored.
- Restart after HALT: `start` → err_code and inst_count cleared, fetch from `imem_addr` 0.

Source files
------------

// File: rtl/inst_fetch.sv
// Instruction fetch/issue stage: fetches the word at the core's PC and issues it as a one-cycle pulse.
// Latency: issue 4 cycles after start or completion with zero-wait memory, plus L-1 for memory latency L.
// Backpressure: one instruction in flight; waits bounded by TIMEOUT, any protocol breach halts with err_code.
module inst_fetch #(
    parameter int IMEM_DEPTH = 352,
    parameter int IMEM_AW    = 9,
    parameter int TIMEOUT    = 10,
    parameter int N_INST     = 1000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               cpu_out_valid,
    input  logic [31:0]        cpu_inst_addr,
    output logic               cpu_in_valid,
    output logic [31:0]        cpu_inst,
    output logic               imem_req,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic               imem_rvalid,
    input  logic [31:0]        imem_rdata,
    output logic               busy,
    output logic               done,
    output logic [2:0]         err_code,
    output logic [31:0]        inst_count
);

    typedef enum logic [2:0] {
        IDLE, CHECK, FETCH, WAIT_MEM, ISSUE, WAIT_CPU, DONE, HALT
    } state_t;

    localparam logic [2:0] ERR_ALIGN = 3'd1;
    localparam logic [2:0] ERR_RANGE = 3'd2;
    localparam logic [2:0] ERR_MEM   = 3'd3;
    localparam logic [2:0] ERR_CPU   = 3'd4;
    localparam logic [2:0] ERR_PROTO = 3'd5;

    localparam int            CNT_W    = $clog2(TIMEOUT) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t           state;
    logic [31:0]      pc;
    logic [CNT_W-1:0] wait_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            pc         <= '0;
            wait_cnt   <= '0;
            cpu_inst   <= '0;
            err_code   <= '0;
            inst_count <= '0;
        end else begin
            // cpu_inst is only non-zero in the single ISSUE cycle
            cpu_inst <= '0;
            // A completion outside WAIT_CPU is a breach; in HALT the first error is kept
            if (cpu_out_valid && state != WAIT_CPU && state != HALT) begin
                state    <= HALT;
                err_code <= ERR_PROTO;
            end else begin
                case (state)
                    IDLE, DONE, HALT: begin
                        if (start) begin
                            pc         <= '0;
                            inst_count <= '0;
                            err_code   <= '0;
                            state      <= CHECK;
                        end
                    end
                    CHECK: begin
                        if (pc[1:0] != 2'b00) begin
                            state    <= HALT;
                            err_code <= ERR_ALIGN;
                        end else if ((pc >> 2) >= 32'(IMEM_DEPTH)) begin
                            state    <= HALT;
                            err_code <= ERR_RANGE;
                        end else begin
                            state <= FETCH;
                        end
                    end
                    FETCH: begin
                        wait_cnt <= '0;
                        state    <= WAIT_MEM;
                    end
                    WAIT_MEM: begin
                        if (imem_rvalid) begin
                            cpu_inst <= imem_rdata;
                            state    <= ISSUE;
                        end else if (wait_cnt == CNT_LAST) begin
                            state    <= HALT;
                            err_code <= ERR_MEM;
                        end else begin
                            wait_cnt <= wait_cnt + 1'b1;
                        end
                    end
                    ISSUE: begin
                        if (inst_count != '1) begin
                            inst_count <= inst_count + 32'd1;
                        end
                        wait_cnt <= '0;
                        state    <= WAIT_CPU;
                    end
                    WAIT_CPU: begin
                        if (cpu_out_valid) begin
                            pc    <= cpu_inst_addr;
                            state <= (inst_count == 32'(N_INST)) ? DONE : CHECK;
                        end else if (wait_cnt == CNT_LAST) begin
                            state    <= HALT;
                            err_code <= ERR_CPU;
                        end else begin
                            wait_cnt <= wait_cnt + 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign cpu_in_valid = (state == ISSUE);
    assign imem_req     = (state == FETCH);
    assign imem_addr    = pc[IMEM_AW+1:2];
    assign busy         = (state != IDLE) && (state != DONE) && (state != HALT);
    assign done         = (state == DONE);

endmodule

// File: tb/tb_inst_fetch.sv
// Scoreboard bench for inst_fetch: directed runs with memory and core models, monitor checks fetch/issue streams.
module tb_inst_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        cpu_out_valid;
    logic [31:0] cpu_inst_addr;
    logic        cpu_in_valid;
    logic [31:0] cpu_inst;
    logic        imem_req;
    logic [8:0]  imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        busy;
    logic        done;
    logic [2:0]  err_code;
    logic [31:0] inst_count;

    inst_fetch #(.IMEM_DEPTH(352), .IMEM_AW(9), .TIMEOUT(10), .N_INST(4)) dut (
        .clk(clk), .rst(rst), .start(start),
        .cpu_out_valid(cpu_out_valid), .cpu_inst_addr(cpu_inst_addr),
        .cpu_in_valid(cpu_in_valid), .cpu_inst(cpu_inst),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .busy(busy), .done(done), .err_code(err_code), .inst_count(inst_count)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    int cyc          = 0;
    int ref_cyc      = 0;
    int ov_first_cyc = 0;
    int req_cyc      = 0;
    int issue_cyc    = 0;
    logic prev_ov    = 1'b0;

    int mem_lat     = 1;
    bit core_silent = 0;
    bit core_double = 0;
    logic [31:0] last_fetch_byte = '0;

    logic [8:0]  fetch_q[$];
    logic [31:0] issue_q[$];
    logic [31:0] ret_q[$];

    function automatic logic [31:0] word(input logic [8:0] a);
        return 32'hC0DE_0000 | {23'd0, a};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_fetch(input logic [8:0] a);
        fetch_q.push_back(a);
    endtask

    task automatic push_both(input logic [8:0] a);
        fetch_q.push_back(a);
        issue_q.push_back(word(a));
    endtask

    // Cycle counter and reference points sampled on the active edge
    initial begin
        forever begin
            @(posedge clk);
            if (cpu_out_valid || (start && !busy)) ref_cyc = cyc;
            if (cpu_out_valid && !prev_ov) ov_first_cyc = cyc;
            prev_ov = cpu_out_valid;
            cyc++;
        end
    end

    // Memory model: rvalid mem_lat cycles after req; mem_lat 0 never answers
    initial begin
        int mcnt = 0;
        logic [8:0] maddr = '0;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        forever begin
            @(negedge clk);
            imem_rvalid = 1'b0;
            imem_rdata  = '0;
            if (mcnt > 0) begin
                mcnt--;
                if (mcnt == 0) begin
                    imem_rvalid = 1'b1;
                    imem_rdata  = word(maddr);
                end
            end
            if (imem_req) begin
                maddr = imem_addr;
                last_fetch_byte = {21'd0, imem_addr, 2'b00};
                if (mem_lat > 0) mcnt = mem_lat;
            end
        end
    end

    // Core model: completes two cycles after each issue with the next PC
    initial begin
        int core_cnt  = 0;
        int core_hold = 0;
        logic [31:0] ret = '0;
        cpu_out_valid = 1'b0;
        cpu_inst_addr = '0;
        forever begin
            @(negedge clk);
            cpu_out_valid = 1'b0;
            if (core_hold > 0) begin
                core_hold--;
                cpu_out_valid = 1'b1;
            end
            if (core_cnt > 0) begin
                core_cnt--;
                if (core_cnt == 0) begin
                    cpu_out_valid = 1'b1;
                    cpu_inst_addr = ret;
                    core_hold = core_double ? 1 : 0;
                end
            end
            if (cpu_in_valid && !core_silent) begin
                core_cnt = 2;
                ret = (ret_q.size() > 0) ? ret_q.pop_front() : last_fetch_byte + 32'd4;
            end
        end
    end

    // Monitor: compares fetch addresses and issued words against the scoreboard
    initial begin
        logic prev_iv = 1'b0;
        forever begin
            @(negedge clk);
            if (imem_req) begin
                req_cyc = cyc;
                if (fetch_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_fetch actual=%0h required=none", imem_addr);
                end else begin
                    chk("fetch_addr", {23'd0, imem_addr}, {23'd0, fetch_q.pop_front()});
                end
            end
            if (cpu_in_valid) begin
                issue_cyc = cyc;
                if (issue_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_issue actual=%0h required=none", cpu_inst);
                end else begin
                    chk("issue_inst", cpu_inst, issue_q.pop_front());
                end
                if (mem_lat == 1) chk("issue_latency", 32'(cyc - ref_cyc), 32'd4);
            end else if (prev_iv) begin
                chk("inst_cleared", cpu_inst, 32'd0);
            end
            prev_iv = cpu_in_valid;
        end
    end

    task automatic wait_idle(input int budget, output int end_c);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy && n < budget);
        if (busy) begin
            checks++;
            failures++;
            $display("FAIL wait_idle actual=busy required=idle after %0d cycles", budget);
        end
        end_c = cyc;
    endtask

    task automatic run_case(input int budget, output int end_c);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("start_err_clr", {29'd0, err_code}, 32'd0);
        chk("start_cnt_clr", inst_count, 32'd0);
        chk("start_busy", {31'd0, busy}, 32'd1);
        wait_idle(budget, end_c);
        repeat (2) @(negedge clk);
        chk("fetch_q_empty", 32'(fetch_q.size()), 32'd0);
        chk("issue_q_empty", 32'(issue_q.size()), 32'd0);
    endtask

    task automatic chk_end(input string name, input logic d, input logic [2:0] e, input logic [31:0] n);
        chk({name, "_done"}, {31'd0, done}, {31'd0, d});
        chk({name, "_err"}, {29'd0, err_code}, {29'd0, e});
        chk({name, "_count"}, inst_count, n);
    endtask

    initial begin
        int end_c;
        rst   = 1'b1;
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_in_valid", {31'd0, cpu_in_valid}, 32'd0);
        chk("rst_inst", cpu_inst, 32'd0);
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_addr", {23'd0, imem_addr}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk_end("rst", 1'b0, 3'd0, 32'd0);
        rst = 1'b0;

        // Sequential run of four instructions
        for (int i = 0; i < 4; i++) push_both(9'(i));
        run_case(200, end_c);
        chk_end("seq", 1'b1, 3'd0, 32'd4);

        // Jump to 0x20 then sequential
        ret_q.push_back(32'h20);
        push_both(9'd0); push_both(9'd8); push_both(9'd9); push_both(9'd10);
        run_case(200, end_c);
        chk_end("jump", 1'b1, 3'd0, 32'd4);

        // Misaligned target: no fetch after the first
        ret_q.push_back(32'h22);
        push_both(9'd0);
        run_case(200, end_c);
        chk_end("misalign", 1'b0, 3'd1, 32'd1);

        // Last valid word then first out-of-range word
        ret_q.push_back(32'h57C);
        ret_q.push_back(32'h580);
        push_both(9'd0); push_both(9'd351);
        run_case(200, end_c);
        chk_end("range", 1'b0, 3'd2, 32'd2);

        // High PC that would alias to word 0 if truncated
        ret_q.push_back(32'h8000_0000);
        push_both(9'd0);
        run_case(200, end_c);
        chk_end("alias", 1'b0, 3'd2, 32'd1);

        // Memory never answers
        mem_lat = 0;
        push_fetch(9'd0);
        run_case(200, end_c);
        chk_end("mem_tmo", 1'b0, 3'd3, 32'd0);
        chk("mem_tmo_cycles", 32'(end_c - req_cyc), 32'd11);

        // Core never completes
        mem_lat = 1;
        core_silent = 1;
        push_both(9'd0);
        run_case(200, end_c);
        chk_end("cpu_tmo", 1'b0, 3'd4, 32'd1);
        chk("cpu_tmo_cycles", 32'(end_c - issue_cyc), 32'd11);

        // Completion held for two cycles
        core_silent = 0;
        core_double = 1;
        push_both(9'd0);
        run_case(200, end_c);
        chk_end("proto", 1'b0, 3'd5, 32'd1);
        chk("proto_cycles", 32'(end_c - ov_first_cyc), 32'd2);

        // Restart after HALT fetches from word 0 again
        core_double = 0;
        for (int i = 0; i < 4; i++) push_both(9'(i));
        run_case(200, end_c);
        chk_end("restart", 1'b1, 3'd0, 32'd4);

        // Reset during WAIT_MEM with the response arriving just after
        mem_lat = 2;
        push_fetch(9'd0);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int n = 0; n < 10 && !imem_req; n++) @(negedge clk);
        chk("rstmid_req_seen", {31'd0, imem_req}, 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rstmid_rvalid_present", {31'd0, imem_rvalid}, 32'd1);
        chk("rstmid_busy", {31'd0, busy}, 32'd0);
        chk("rstmid_in_valid", {31'd0, cpu_in_valid}, 32'd0);
        chk("rstmid_req", {31'd0, imem_req}, 32'd0);
        chk("rstmid_addr", {23'd0, imem_addr}, 32'd0);
        chk_end("rstmid", 1'b0, 3'd0, 32'd0);
        repeat (3) @(negedge clk);
        chk("rstmid_still_idle", {31'd0, busy}, 32'd0);
        chk("rstmid_inst", cpu_inst, 32'd0);
        chk("rstmid_issue_q", 32'(issue_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
